scr1_dmem_initiator: RTL
========================

Name: scr1_dmem_initiator

Overview:
- Initiator (core-side master) on the SCR1 data-memory interface; the counterpart of TCM/bridge responders.
- Accepts one load/store command at a time from a client (LSU-style valid/ready) and issues it as a dmem_req/dmem_req_ack/dmem_resp transaction.
- Checks alignment, sign/zero-extends read data and reports bus error or response timeout.
- Sits between core execution logic and any dmem responder (TCM, AHB/AXI bridge, router).

Parameters:
- SCR1_DMEM_AWIDTH, 32, address width.
- RESP_TIMEOUT, 255, WAIT_RESP cycles before a timeout error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  client command valid
- cmd_ready  out  1  block can accept a command
- cmd_wr  in  1  1=store, 0=load
- cmd_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
- cmd_unsigned  in  1  zero-extend load (else sign-extend)
- cmd_addr  in  SCR1_DMEM_AWIDTH  byte address
- cmd_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores/errors)
- rsp_err  out  2  0=OK, 1=bus error, 2=misaligned, 3=timeout
- dmem_req  out  1  request to responder
- dmem_req_ack  in  1  responder accepted request
- dmem_cmd  out  type_scr1_mem_cmd_e  RD/WR
- dmem_width  out  type_scr1_mem_width_e  access width
- dmem_addr  out  SCR1_DMEM_AWIDTH  access address
- dmem_wdata  out  32  write data, LSB-aligned
- dmem_rdata  in  32  read data, LSB-aligned by responder
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER

Behaviour:
- Reset: clk, rst_n (asynchronous, active-low). State IDLE. cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dmem_req=0. dmem_addr/dmem_wdata=0, dmem_cmd=RD, dmem_width=WORD. Stale flag=0, timeout counter=0.
- FSM states: IDLE, REQ, WAIT_RESP.
- cmd_ready = (state==IDLE) & ~stale. A command is accepted on cmd_valid & cmd_ready.
- Misalignment:
  - HWORD with addr[0]=1 is misaligned.
  - WORD with addr[1:0]!=0 is misaligned.
  - A misaligned command issues no bus request. The state stays IDLE; next cycle rsp_valid=1, rsp_err=2, rsp_rdata=0.
- Aligned accept: register addr/width/cmd/wdata/unsigned into dmem_* outputs; next state REQ.
- REQ:
  - dmem_req=1.
  - All dmem_* outputs stay stable until dmem_req_ack.
  - On ack: dmem_req drops next cycle; state → WAIT_RESP; counter cleared.
- WAIT_RESP: dmem_resp sampled every cycle.
  - RDY_OK, load: rsp_rdata = extend(dmem_rdata). Byte uses bit 7; HWORD uses bit 15; zero-extend if cmd_unsigned; WORD passes through. rsp_err=0.
  - RDY_OK, store: rsp_rdata=0, rsp_err=0.
  - RDY_ER: rsp_err=1, rsp_rdata=0.
  - Any response: rsp_valid pulses on the following cycle; state → IDLE.
  - NOTRDY: counter increments.
    - When counter==RESP_TIMEOUT-1 and RESP_TIMEOUT!=0: rsp_valid with rsp_err=3, state → IDLE, stale=1.
    - Counter saturates; it does not wrap.
- Stale flag:
  - While stale=1, cmd_ready=0.
  - The first later non-NOTRDY dmem_resp clears stale and is discarded; no rsp_valid.
- Latency with a zero-wait responder (ack same cycle, resp next cycle): accept T, req T+1, resp T+2, rsp_valid T+3. Throughput 1 command per 3 cycles.
- rsp_valid is high for exactly one cycle. rsp_rdata/rsp_err hold their values until the next response.
- Simultaneous events:
  - cmd_valid during REQ/WAIT_RESP is ignored (cmd_ready=0).
  - A response arriving in REQ before ack is ignored.
- Reset mid-operation: dmem_req drops asynchronously. Any in-flight transaction is abandoned without rsp_valid.

Decomposition:
- Enum types type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e come from the shared memif package.
- The rsp_err encoding (OK/BUSERR/MISALIGN/TIMEOUT) is a new enum type_scr1_dmem_err_e in the same package.
- One natural sub-module: scr1_dmem_load_ext, the combinational width/sign extender, reusable by the imem-side fetch logic.

Test Plan:
- Load byte, addr 0x103, unsigned=0; responder returns rdata=0x000000F5, RDY_OK → rsp_valid at T+3, rdata=0xFFFFFFF5, err=0; dmem_addr=0x103, width=BYTE.
- Store HWORD, addr 0x202, wdata=0x0000BEEF; responder holds req_ack=0 for 3 cycles → dmem_req/addr/wdata stable all 4 cycles, then rsp err=0, rdata=0.
- Load WORD, addr 0x006 → no dmem_req ever; rsp_valid next cycle, err=2.
- Load HWORD unsigned, addr 0x40; responder returns 0x00008001, RDY_ER → err=1, rdata=0.
- RESP_TIMEOUT=4; responder acks but holds NOTRDY → err=3 after 4 WAIT cycles, cmd_ready=0. A late RDY_OK produces no rsp_valid, and cmd_ready returns to 1 the next cycle.
- rst_n pulled low while in WAIT_RESP → dmem_req=0 and rsp_valid=0 immediately; after release cmd_ready=1 and a new load completes normally.

Source files
------------

// File: rtl/scr1_dmem_initiator_pkg.sv
// Shared memif types for the SCR1 data-memory initiator and its helpers.
package scr1_dmem_initiator_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'd0,
    SCR1_MEM_WIDTH_HWORD = 2'd1,
    SCR1_MEM_WIDTH_WORD  = 2'd2
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'd0,
    SCR1_MEM_RESP_RDY_OK = 2'd1,
    SCR1_MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_DMEM_ERR_OK       = 2'd0,
    SCR1_DMEM_ERR_BUSERR   = 2'd1,
    SCR1_DMEM_ERR_MISALIGN = 2'd2,
    SCR1_DMEM_ERR_TIMEOUT  = 2'd3
  } type_scr1_dmem_err_e;

  typedef enum logic [1:0] {
    SCR1_DMEM_FSM_IDLE      = 2'd0,
    SCR1_DMEM_FSM_REQ       = 2'd1,
    SCR1_DMEM_FSM_WAIT_RESP = 2'd2
  } type_scr1_dmem_fsm_e;

  function automatic logic scr1_dmem_misaligned(input type_scr1_mem_width_e width,
                                                input logic [1:0] addr_lsb);
    logic mis;
    case (width)
      SCR1_MEM_WIDTH_HWORD: mis = addr_lsb[0];
      SCR1_MEM_WIDTH_WORD:  mis = |addr_lsb;
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/scr1_dmem_load_ext.sv
// Combinational load-data extender: byte/halfword sign or zero extension,
// words pass through. Shared with the fetch side.
module scr1_dmem_load_ext
  import scr1_dmem_initiator_pkg::*;
(
  input  type_scr1_mem_width_e width,
  input  logic                 is_unsigned,
  input  logic [31:0]          rdata,
  output logic [31:0]          ext_data
);

  always_comb begin
    ext_data = rdata;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  ext_data = {{24{~is_unsigned & rdata[7]}}, rdata[7:0]};
      SCR1_MEM_WIDTH_HWORD: ext_data = {{16{~is_unsigned & rdata[15]}}, rdata[15:0]};
      default:              ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/scr1_dmem_initiator.sv
// Core-side dmem initiator: one outstanding load/store, alignment check,
// load extension, bus-error and response-timeout reporting.
module scr1_dmem_initiator
  import scr1_dmem_initiator_pkg::*;
#(
  parameter int SCR1_DMEM_AWIDTH = 32,
  parameter int RESP_TIMEOUT     = 255
)
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_wr,
  input  type_scr1_mem_width_e        cmd_width,
  input  logic                        cmd_unsigned,
  input  logic [SCR1_DMEM_AWIDTH-1:0] cmd_addr,
  input  logic [31:0]                 cmd_wdata,
  output logic                        rsp_valid,
  output logic [31:0]                 rsp_rdata,
  output type_scr1_dmem_err_e         rsp_err,
  output logic                        dmem_req,
  input  logic                        dmem_req_ack,
  output type_scr1_mem_cmd_e          dmem_cmd,
  output type_scr1_mem_width_e        dmem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  output logic [31:0]                 dmem_wdata,
  input  logic [31:0]                 dmem_rdata,
  input  type_scr1_mem_resp_e         dmem_resp
);

  localparam int               CNT_W    = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  type_scr1_dmem_fsm_e state_r, state_nxt;
  type_scr1_dmem_err_e rsp_err_nxt;
  logic                stale_r, stale_nxt;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt;
  logic                is_unsigned_r;
  logic                req_nxt, rsp_valid_nxt, cmd_load;
  logic [31:0]         rsp_rdata_nxt, ext_data;
  logic                accept, misaligned, resp_any, timeout_hit;

  assign cmd_ready   = (state_r == SCR1_DMEM_FSM_IDLE) & ~stale_r;
  assign accept      = cmd_valid & cmd_ready;
  assign misaligned  = scr1_dmem_misaligned(cmd_width, cmd_addr[1:0]);
  assign resp_any    = (dmem_resp != SCR1_MEM_RESP_NOTRDY);
  assign timeout_hit = (RESP_TIMEOUT != 0) && (cnt_r == CNT_LAST);

  scr1_dmem_load_ext u_load_ext (
    .width       (dmem_width),
    .is_unsigned (is_unsigned_r),
    .rdata       (dmem_rdata),
    .ext_data    (ext_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= SCR1_DMEM_FSM_IDLE;
    else        state_r <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      SCR1_DMEM_FSM_IDLE:
        if (accept & ~misaligned) state_nxt = SCR1_DMEM_FSM_REQ;
        else                      state_nxt = SCR1_DMEM_FSM_IDLE;
      SCR1_DMEM_FSM_REQ:
        if (dmem_req_ack) state_nxt = SCR1_DMEM_FSM_WAIT_RESP;
        else              state_nxt = SCR1_DMEM_FSM_REQ;
      SCR1_DMEM_FSM_WAIT_RESP:
        if (resp_any | timeout_hit) state_nxt = SCR1_DMEM_FSM_IDLE;
        else                        state_nxt = SCR1_DMEM_FSM_WAIT_RESP;
      default: state_nxt = SCR1_DMEM_FSM_IDLE;
    endcase
  end

  // Output/next-value logic for the registered outputs and side state
  always_comb begin
    req_nxt       = dmem_req;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    stale_nxt     = stale_r;
    cnt_nxt       = cnt_r;
    cmd_load      = 1'b0;
    case (state_r)
      SCR1_DMEM_FSM_IDLE: begin
        // A timed-out transaction's late response is swallowed here
        if (stale_r) begin
          if (resp_any) stale_nxt = 1'b0;
          else          stale_nxt = 1'b1;
        end else if (accept) begin
          if (misaligned) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = SCR1_DMEM_ERR_MISALIGN;
            rsp_rdata_nxt = 32'd0;
          end else begin
            req_nxt  = 1'b1;
            cmd_load = 1'b1;
          end
        end else begin
          req_nxt = 1'b0;
        end
      end
      SCR1_DMEM_FSM_REQ: begin
        if (dmem_req_ack) begin
          req_nxt = 1'b0;
          cnt_nxt = '0;
        end else begin
          req_nxt = 1'b1;
        end
      end
      SCR1_DMEM_FSM_WAIT_RESP: begin
        if (resp_any) begin
          rsp_valid_nxt = 1'b1;
          if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
            rsp_err_nxt   = SCR1_DMEM_ERR_OK;
            rsp_rdata_nxt = (dmem_cmd == SCR1_MEM_CMD_WR) ? 32'd0 : ext_data;
          end else begin
            rsp_err_nxt   = SCR1_DMEM_ERR_BUSERR;
            rsp_rdata_nxt = 32'd0;
          end
        end else if (timeout_hit) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = SCR1_DMEM_ERR_TIMEOUT;
          rsp_rdata_nxt = 32'd0;
          stale_nxt     = 1'b1;
        end else begin
          cnt_nxt = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: req_nxt = 1'b0;
    endcase
  end

  // Registered outputs, command latch and timeout bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req      <= 1'b0;
      dmem_cmd      <= SCR1_MEM_CMD_RD;
      dmem_width    <= SCR1_MEM_WIDTH_WORD;
      dmem_addr     <= '0;
      dmem_wdata    <= 32'd0;
      is_unsigned_r <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_err       <= SCR1_DMEM_ERR_OK;
      stale_r       <= 1'b0;
      cnt_r         <= '0;
    end else begin
      dmem_req  <= req_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      stale_r   <= stale_nxt;
      cnt_r     <= cnt_nxt;
      if (cmd_load) begin
        dmem_cmd      <= cmd_wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        dmem_width    <= cmd_width;
        dmem_addr     <= cmd_addr;
        dmem_wdata    <= cmd_wdata;
        is_unsigned_r <= cmd_unsigned;
      end else begin
        is_unsigned_r <= is_unsigned_r;
      end
    end
  end

endmodule
